// File: rtl/dtcm_lsu.sv
// Load/store initiator for the single-port, word-wide D-TCM: byte/half/word loads with extension,
// sub-word stores as read-modify-write. Optional error counter: define DTCM_LSU_ERR_CNT_EN.
module dtcm_lsu #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned REQ_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [REQ_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [15:0]               err_count
);

  typedef enum logic {IDLE, RMW_WR} state_e;

  state_e state_q, state_d;

  logic hs, req_err, sub_store, rmw_start, word_store;

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic                  ld_q, ld_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic [1:0]            ld_lane_q, ld_lane_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [1:0]            rmw_lane_q, rmw_lane_d;
  logic                  rmw_half_q, rmw_half_d;
  logic [15:0]           rmw_wdata_q, rmw_wdata_d;
  logic [DATA_WIDTH-1:0] merged;

  // Request decode and error classification
  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
            | (|req_addr[REQ_ADDR_WIDTH-1:ADDR_WIDTH+2]);
    hs         = req_valid & req_ready;
    sub_store  = req_we & ~req_size[1];
    rmw_start  = hs & ~req_err & sub_store;
    word_store = hs & ~req_err & req_we & (req_size == 2'b10);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rmw_start) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane merge for the write half of a sub-word store; mem_rdata holds the word read at T
  always_comb begin
    merged = mem_rdata;
    if (rmw_half_q) merged[{rmw_lane_q[1], 4'b0000} +: 16] = rmw_wdata_q;
    else            merged[{rmw_lane_q, 3'b000} +: 8]     = rmw_wdata_q[7:0];
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == IDLE) & ~rst;
    mem_we    = 1'b0;
    mem_addr  = req_addr[ADDR_WIDTH+1:2];
    mem_wdata = req_wdata;
    case (state_q)
      RMW_WR: begin
        mem_we    = ~rst;
        mem_addr  = rmw_addr_q;
        mem_wdata = merged;
      end
      default: mem_we = word_store;
    endcase
  end

  // Response and capture registers
  always_comb begin
    resp_valid_d = hs ? ~rmw_start : (state_q == RMW_WR);
    resp_err_d   = hs & req_err;
    ld_d         = hs & ~req_err & ~req_we;
    ld_size_d    = hs ? req_size     : ld_size_q;
    ld_lane_d    = hs ? req_addr[1:0] : ld_lane_q;
    ld_uns_d     = hs ? req_unsigned : ld_uns_q;
    rmw_addr_d   = rmw_start ? req_addr[ADDR_WIDTH+1:2] : rmw_addr_q;
    rmw_lane_d   = rmw_start ? req_addr[1:0]            : rmw_lane_q;
    rmw_half_d   = rmw_start ? req_size[0]              : rmw_half_q;
    rmw_wdata_d  = rmw_start ? req_wdata[15:0]          : rmw_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      ld_q         <= 1'b0;
      ld_size_q    <= '0;
      ld_lane_q    <= '0;
      ld_uns_q     <= 1'b0;
      rmw_addr_q   <= '0;
      rmw_lane_q   <= '0;
      rmw_half_q   <= 1'b0;
      rmw_wdata_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      ld_q         <= ld_d;
      ld_size_q    <= ld_size_d;
      ld_lane_q    <= ld_lane_d;
      ld_uns_q     <= ld_uns_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_lane_q   <= rmw_lane_d;
      rmw_half_q   <= rmw_half_d;
      rmw_wdata_q  <= rmw_wdata_d;
    end
  end

  // Load data extraction from the registered TCM read
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    ld_byte    = mem_rdata[{ld_lane_q, 3'b000} +: 8];
    ld_half    = mem_rdata[{ld_lane_q[1], 4'b0000} +: 16];
    resp_rdata = '0;
    if (resp_valid_q && ld_q) begin
      case (ld_size_q)
        2'b00:   resp_rdata = {{(DATA_WIDTH-8){~ld_uns_q & ld_byte[7]}}, ld_byte};
        2'b01:   resp_rdata = {{(DATA_WIDTH-16){~ld_uns_q & ld_half[15]}}, ld_half};
        default: resp_rdata = mem_rdata;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

`ifdef DTCM_LSU_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;
  always_comb begin
    err_count_d = err_count_q;
    if (hs && req_err && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end
  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_dtcm_lsu.sv
// Self-checking bench for dtcm_lsu: behavioural D-TCM with registered read, response scoreboard.
module tb_dtcm_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] err_count;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] sb[$];
  logic [31:0] tcm[1024];

  dtcm_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .REQ_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // D-TCM model: one-cycle registered read, read-before-write
  always @(posedge clk) begin
    if (mem_we) tcm[mem_addr] <= mem_wdata;
    mem_rdata <= tcm[mem_addr];
  end

  // Scoreboard: every response pops the oldest expected {err, rdata}
  always @(negedge clk) begin
    if (resp_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got err=%0b rdata=%08h, required no response", resp_err, resp_rdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          miscompares++;
          $display("FAIL resp: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    sb.push_back({exp_err, exp_rdata});
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0);
    void'(sb.pop_back());
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0 || mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_hold: got ready=%0b we=%0b, required 0 0", req_ready, mem_we);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_err, err_count} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL rst_state: got ready=%0b rv=%0b re=%0b cnt=%0h, required 1 0 0 0",
               req_ready, resp_valid, resp_err, err_count);
    end
  endtask

  task automatic test_word_store_load();
    @(posedge clk); #1;
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd4, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL wstore_issue: got we=%0b addr=%0d wdata=%08h, required 1 4 deadbeef",
               mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL wload_issue: got we=%0b, required 0", mem_we);
    end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_load_ext();
    tcm[4] = 32'h80FF7F01;
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00007F01, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h000080FF, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_rmw();
    tcm[4] = 32'h11223344;
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_T: got we=%0b, required 0", mem_we);
    end
    idle_cycle();
    @(negedge clk);
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, req_ready, resp_valid} !== {1'b1, 10'd4, 32'h1122AB44, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rmw_T1: got we=%0b addr=%0d wdata=%08h ready=%0b rv=%0b, required 1 4 1122ab44 0 0",
               mem_we, mem_addr, mem_wdata, req_ready, resp_valid);
    end
    @(posedge clk); #1;
    // Half store into the upper lane, issued the cycle the byte store responds
    drive(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || tcm[4] !== 32'h1122AB44) begin
      miscompares++;
      $display("FAIL rmw_T2: got rv=%0b tcm4=%08h, required 1 1122ab44", resp_valid, tcm[4]);
    end
    idle_cycle();
    @(posedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFAB44, 1'b0);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    tcm[0] = 32'hA0A0A0A0;
    tcm[1] = 32'hB1B1B1B1;
    tcm[2] = 32'hC2C2C2C2;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp;
      exp = (i == 0) ? 32'hA0A0A0A0 : (i == 1) ? 32'hB1B1B1B1 : 32'hC2C2C2C2;
      drive(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, exp, 1'b0);
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || (i > 0 && resp_valid !== 1'b1)) begin
        miscompares++;
        $display("FAIL b2b_%0d: got ready=%0b rv=%0b, required 1 %0b", i, req_ready, resp_valid, i > 0);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_last: got rv=%0b, required 1", resp_valid);
    end
    idle_cycle();
  endtask

  task automatic test_errors();
    logic [2:0][31:0] addrs;
    logic [2:0][1:0]  sizes;
    logic [2:0]       wes;
    addrs = {32'h0, 32'h1000, 32'h3};
    sizes = {2'b11, 2'b10, 2'b01};
    wes   = {1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF, 32'h0, 1'b1);
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL err_we_%0d: got we=%0b, required 0", i, mem_we);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    idle_cycle();
    @(negedge clk);
    vectors++;
`ifdef DTCM_LSU_ERR_CNT_EN
    if (err_count !== 16'd3) begin
      miscompares++;
      $display("FAIL err_count: got %0d, required 3", err_count);
    end
`else
    if (err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL err_count: got %0d, required 0", err_count);
    end
`endif
  endtask

  task automatic test_rst_in_rmw();
    tcm[5] = 32'h55667788;
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000099, 32'h0, 1'b0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rmw_we: got we=%0b ready=%0b, required 0 0", mem_we, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_rmw_quiet_%0d: got rv=%0b ready=%0b, required 0 1", i, resp_valid, req_ready);
      end
    end
    vectors++;
    if (tcm[5] !== 32'h55667788 || err_count !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_rmw_mem: got tcm5=%08h cnt=%0h, required 55667788 0", tcm[5], err_count);
    end
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'h00000088, 1'b0);
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rst = 1'b1;
    for (int i = 0; i < 1024; i++) tcm[i] = '0;
    test_reset();
    test_word_store_load();
    test_load_ext();
    test_rmw();
    test_back_to_back();
    test_errors();
    test_rst_in_rmw();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

endmodule
